// File: rtl/cpu_debug_unit.sv
// Host-side debug controller for the multicycle CPU: conditions board buttons,
// sequences run/step control and muxes CPU readback onto a registered display bus.

module cpu_debug_btn #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync1, sync2;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Rising edge of the debounced level only; release produces nothing.
  assign pulse = level & ~level_q;
endmodule

module cpu_debug_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        succ,
  input  logic        step,
  input  logic        inc,
  input  logic        dec,
  input  logic        m_rf,
  input  logic [1:0]  sel,
  input  logic [31:0] pc,
  input  logic [31:0] mem_data,
  input  logic [31:0] reg_data,
  output logic        run,
  output logic        enable,
  output logic [7:0]  addr,
  output logic [31:0] disp
);
  localparam int TW = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  state_t        state, state_next;
  logic          step_p, inc_p, dec_p;
  logic          succ_s1, succ_s;
  logic [31:0]   pc_snap;
  logic [TW-1:0] step_timer;
  logic [15:0]   step_cnt;
  logic          step_done;
  logic          step_start;

  cpu_debug_btn #(.CYCLES(DEBOUNCE_CYCLES)) u_step (.clk(clk), .rst(rst), .raw(step), .pulse(step_p));
  cpu_debug_btn #(.CYCLES(DEBOUNCE_CYCLES)) u_inc  (.clk(clk), .rst(rst), .raw(inc),  .pulse(inc_p));
  cpu_debug_btn #(.CYCLES(DEBOUNCE_CYCLES)) u_dec  (.clk(clk), .rst(rst), .raw(dec),  .pulse(dec_p));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      succ_s1 <= 1'b0;
      succ_s  <= 1'b0;
    end else begin
      succ_s1 <= succ;
      succ_s  <= succ_s1;
    end
  end

  // A step ends on the first observed PC change, or after the self-loop guard expires.
  assign step_done  = (pc != pc_snap) || (step_timer == TIMER_LAST);
  assign step_start = (state == IDLE) && !succ_s && step_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (succ_s)      state_next = RUN;
        else if (step_p) state_next = STEP;
      end
      RUN:  if (!succ_s)   state_next = IDLE;
      STEP: if (step_done) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_comb begin
    run    = 1'b0;
    enable = 1'b0;
    unique case (state)
      RUN:  run = 1'b1;
      STEP: begin
        run    = 1'b1;
        enable = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_snap    <= '0;
      step_timer <= '0;
      step_cnt   <= '0;
    end else if (step_start) begin
      pc_snap    <= pc;
      step_timer <= '0;
    end else if (state == STEP) begin
      step_timer <= step_timer + TW'(1);
      if (step_done) step_cnt <= step_cnt + 16'd1;
    end
  end

  // Simultaneous inc/dec pulses cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 addr <= '0;
    else if (inc_p && !dec_p) addr <= addr + 8'd1;
    else if (dec_p && !inc_p) addr <= addr - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp <= '0;
    end else begin
      unique case (sel)
        2'd0: disp <= m_rf ? mem_data : reg_data;
        2'd1: disp <= pc;
        2'd2: disp <= {24'b0, addr};
        2'd3: disp <= {16'b0, step_cnt};
        default: disp <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_debug_unit.sv
// Scoreboard bench for cpu_debug_unit: expectations are queued as stimulus is
// applied and retired against DUT outputs sampled on the falling clock edge.

module tb_cpu_debug_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        succ, step, inc, dec, m_rf;
  logic [1:0]  sel;
  logic [31:0] pc, mem_data, reg_data;
  logic        run, enable;
  logic [7:0]  addr;
  logic [31:0] disp;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];

  cpu_debug_unit #(.DEBOUNCE_CYCLES(4), .STEP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .succ(succ), .step(step), .inc(inc), .dec(dec),
    .m_rf(m_rf), .sel(sel), .pc(pc), .mem_data(mem_data), .reg_data(reg_data),
    .run(run), .enable(enable), .addr(addr), .disp(disp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic observe(input logic [31:0] got);
    if (tag_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow: got 0x%08h with no expectation queued", got);
    end else begin
      check(tag_q.pop_front(), got, val_q.pop_front());
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // mask = {step, inc, dec}; held long enough to debounce, then released and settled.
  task automatic press(input logic [2:0] mask);
    {step, inc, dec} = mask;
    tick(12);
    {step, inc, dec} = 3'b000;
    tick(12);
  endtask

  // Presses step, counts run/enable cycles; pc switches to pc_new on run cycle change_at (0 = never).
  task automatic run_step(input logic [31:0] pc_start, input logic [31:0] pc_new,
                          input int change_at, output int run_cyc, output int en_cyc);
    int guard = 0;
    pc      = pc_start;
    step    = 1'b1;
    run_cyc = 0;
    en_cyc  = 0;
    while (!run && guard < 40) begin
      tick(1);
      guard++;
    end
    check("step_started", {31'b0, run}, 32'd1);
    while (run && guard < 120) begin
      run_cyc++;
      if (enable) en_cyc++;
      if (run_cyc == change_at) pc = pc_new;
      tick(1);
      guard++;
    end
    step = 1'b0;
    tick(12);
  endtask

  initial begin
    int rc, ec;
    rst = 1'b1;
    {succ, step, inc, dec, m_rf} = 5'b0;
    sel = 2'd0; pc = '0; mem_data = '0; reg_data = '0;

    // Reset state
    expect_val("rst_run", 0); expect_val("rst_enable", 0);
    expect_val("rst_addr", 0); expect_val("rst_disp", 0);
    tick(3);
    observe({31'b0, run}); observe({31'b0, enable}); observe({24'b0, addr}); observe(disp);
    rst = 1'b0;
    tick(2);

    // Debounce: bounce then hold high; addr moves exactly once on the 7th edge
    for (int i = 0; i < 6; i++) begin
      inc = ~i[0];
      tick(1);
    end
    inc = 1'b1;
    expect_val("deb_before", 0); expect_val("deb_after", 1); expect_val("deb_hold", 1);
    tick(6);  observe({24'b0, addr});
    tick(1);  observe({24'b0, addr});
    tick(20); observe({24'b0, addr});
    inc = 1'b0;
    tick(12);

    // Address wrap in both directions and inc/dec cancel
    do_reset();
    expect_val("wrap_dec", 8'd255); press(3'b001); observe({24'b0, addr});
    expect_val("wrap_inc", 8'd0);   press(3'b010); observe({24'b0, addr});
    expect_val("inc_dec_same", 8'd0); press(3'b011); observe({24'b0, addr});

    // Single step ending on a PC change after 5 run cycles
    sel = 2'd3;
    expect_val("step_run_cycles", 5); expect_val("step_en_cycles", 5);
    expect_val("step_idle", 0); expect_val("step_cnt_1", 1);
    run_step(32'h0, 32'h4, 5, rc, ec);
    observe(rc); observe(ec); observe({31'b0, run}); observe(disp);

    // Self-loop: PC never moves, guard ends the step after 16 cycles
    expect_val("loop_run_cycles", 16); expect_val("loop_en_cycles", 16);
    expect_val("loop_idle", 0); expect_val("step_cnt_2", 2);
    run_step(32'h10, 32'h10, 0, rc, ec);
    observe(rc); observe(ec); observe({31'b0, run}); observe(disp);

    // Continuous run: 3-cycle latency each way, steps ignored meanwhile
    succ = 1'b1;
    expect_val("succ_run_early", 0); expect_val("succ_run", 1); expect_val("succ_enable", 0);
    tick(2); observe({31'b0, run});
    tick(1); observe({31'b0, run}); observe({31'b0, enable});
    expect_val("run_step_ignored", 2);
    press(3'b100); observe(disp);
    succ = 1'b0;
    expect_val("unsucc_run_late", 1); expect_val("unsucc_run", 0);
    tick(2); observe({31'b0, run});
    tick(1); observe({31'b0, run});

    // Readback mux
    press(3'b010); press(3'b010); press(3'b010);
    mem_data = 32'hDEAD_BEEF; reg_data = 32'h1234_5678;
    sel = 2'd2;              expect_val("disp_addr", 3);              tick(1); observe(disp);
    sel = 2'd0; m_rf = 1'b1; expect_val("disp_mem", 32'hDEAD_BEEF);   tick(1); observe(disp);
    m_rf = 1'b0;             expect_val("disp_reg", 32'h1234_5678);   tick(1); observe(disp);
    sel = 2'd1;              expect_val("disp_pc", 32'h10);           tick(1); observe(disp);

    // Asynchronous reset in the middle of a step
    sel = 2'd3;
    pc = 32'h10;
    step = 1'b1;
    for (int g = 0; g < 40 && !run; g++) tick(1);
    tick(2);
    expect_val("mid_rst_run", 0); expect_val("mid_rst_enable", 0);
    expect_val("mid_rst_addr", 0); expect_val("mid_rst_disp", 0);
    #1 rst = 1'b1;
    #1;
    observe({31'b0, run}); observe({31'b0, enable}); observe({24'b0, addr}); observe(disp);
    @(negedge clk);
    rst = 1'b0;

    // Button held through reset yields one fresh step after release
    expect_val("held_run_cycles", 16); expect_val("held_step_cnt", 1);
    run_step(32'h10, 32'h10, 0, rc, ec);
    observe(rc); observe(disp);

    if (tag_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expectations never observed", tag_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
